// File: rtl/phase_decoder_seq.sv
// Timed phase sequencer: walks a phase index 0..last_phase and holds each
// phase for its own dwell count. It drives a registered one-hot decode of the
// index and a strobe in the first cycle of each phase.
module phase_decoder_seq #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            hold,
  input  logic                            adv_req,
  input  logic [SEL_W-1:0]                last_phase,
  input  logic [(2**SEL_W)*DWELL_W-1:0]   dwell_bus,
  output logic [SEL_W-1:0]                phase_idx,
  output logic [(2**SEL_W)-1:0]           phase_oh,
  output logic                            phase_start,
  output logic [DWELL_W-1:0]              cnt_q
);

  localparam int NPH = 2**SEL_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [NPH-1:0]     oh_q, oh_d;
  logic               start_q, start_d;
  logic [DWELL_W-1:0] cnt_d;
  logic [SEL_W-1:0]   next_idx;

  // Unpack the flat dwell bus into one entry per phase.
  logic [DWELL_W-1:0] dwell_arr [NPH];

  genvar gi;
  generate
    for (gi = 0; gi < NPH; gi++) begin : g_dwell
      assign dwell_arr[gi] = dwell_bus[gi*DWELL_W +: DWELL_W];
    end
  endgenerate

  // Wrap uses >= so that lowering last_phase below the current index still
  // returns to phase 0 once the current phase finishes.
  always_comb begin
    next_idx = '0;
    if (idx_q < last_phase) begin
      next_idx = idx_q + SEL_W'(1);
    end
  end

  // Next-state logic. Priority: enable low, then hold, then advance, then count down.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        oh_d  = '0;
        cnt_d = '0;
        if (en) begin
          state_d  = ST_RUN;
          oh_d[0]  = 1'b1;
          start_d  = 1'b1;
          cnt_d    = dwell_arr[0];
        end
      end
      default: begin
        if (!en) begin
          // Progress is discarded; re-enable restarts from phase 0.
          state_d = ST_IDLE;
          idx_d   = '0;
          oh_d    = '0;
          cnt_d   = '0;
        end else if (hold) begin
          // Freeze everything; a coincident adv_req is dropped, not latched.
          idx_d = idx_q;
        end else if ((cnt_q == '0) || adv_req) begin
          // Expiry and forced advance collapse into a single advance.
          idx_d          = next_idx;
          oh_d           = '0;
          oh_d[next_idx] = 1'b1;
          cnt_d          = dwell_arr[next_idx];
          start_d        = 1'b1;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
    endcase
  end

  // State and output registers; the one-hot is held in its own register so
  // the lamp drive never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      oh_q    <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_idx   = idx_q;
  assign phase_oh    = oh_q;
  assign phase_start = start_q;

endmodule

// File: tb/tb_phase_decoder_seq.sv
// Directed bench for phase_decoder_seq: a 4-phase instance for the main
// scenarios and an 8-phase instance for the all-zero-dwell walk.
module tb_phase_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, hold, adv_req;
  logic [1:0]  last_phase;
  logic [15:0] dwell_bus;
  logic [1:0]  phase_idx;
  logic [3:0]  phase_oh;
  logic        phase_start;
  logic [3:0]  cnt_q;

  logic        en8, hold8, adv8;
  logic [2:0]  last8;
  logic [31:0] dwell8;
  logic [2:0]  idx8;
  logic [7:0]  oh8;
  logic        start8;
  logic [3:0]  cnt8;

  int n_vec = 0;
  int n_err = 0;

  // Nominal period with dwell 2,0,1,3: 0001x3 0010x1 0100x2 1000x4 then 0001.
  int t1_oh [11] = '{1, 1, 1, 2, 4, 4, 8, 8, 8, 8, 1};
  int t1_st [11] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1};
  int t1_cn [11] = '{2, 1, 0, 0, 1, 0, 3, 2, 1, 0, 2};
  // Wrap at last_phase=1: 0001x3 0010x1 repeating.
  int t4_oh [8]  = '{1, 1, 2, 1, 1, 1, 2, 1};
  int t4_st [8]  = '{0, 0, 1, 1, 0, 0, 1, 1};
  int t4_cn [8]  = '{1, 0, 0, 2, 1, 0, 0, 2};

  always #5 clk = ~clk;

  phase_decoder_seq #(.SEL_W(2), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .adv_req(adv_req),
    .last_phase(last_phase), .dwell_bus(dwell_bus),
    .phase_idx(phase_idx), .phase_oh(phase_oh),
    .phase_start(phase_start), .cnt_q(cnt_q)
  );

  phase_decoder_seq #(.SEL_W(3), .DWELL_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .hold(hold8), .adv_req(adv8),
    .last_phase(last8), .dwell_bus(dwell8),
    .phase_idx(idx8), .phase_oh(oh8),
    .phase_start(start8), .cnt_q(cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int idx, input int oh, input int st, input int cn);
    chk({tag, ".idx"},   32'(phase_idx),   32'(idx));
    chk({tag, ".oh"},    32'(phase_oh),    32'(oh));
    chk({tag, ".start"}, 32'(phase_start), 32'(st));
    chk({tag, ".cnt"},   32'(cnt_q),       32'(cn));
  endtask

  task automatic chk8(input string tag, input int idx, input int oh, input int st, input int cn);
    chk({tag, ".idx"},   32'(idx8),   32'(idx));
    chk({tag, ".oh"},    32'(oh8),    32'(oh));
    chk({tag, ".start"}, 32'(start8), 32'(st));
    chk({tag, ".cnt"},   32'(cnt8),   32'(cn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; hold = 1'b0; adv_req = 1'b0;
    last_phase = 2'd3; dwell_bus = 16'h3102;
    en8 = 1'b0; hold8 = 1'b0; adv8 = 1'b0; last8 = 3'd7; dwell8 = 32'h0;
    step(); step();
    chk4("reset", 0, 0, 0, 0);
    chk8("reset8", 0, 0, 0, 0);

    // 1: nominal cycle
    rst_n = 1'b1; en = 1'b1;
    step();
    chk4("nom0", 0, t1_oh[0], t1_st[0], t1_cn[0]);
    for (int i = 1; i < 11; i++) begin
      step();
      chk4($sformatf("nom%0d", i), $clog2(t1_oh[i]), t1_oh[i], t1_st[i], t1_cn[i]);
    end

    // 2: hold in phase 3 with cnt_q=1
    for (int i = 0; i < 8; i++) step();
    chk4("prehold", 3, 8, 0, 1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk4($sformatf("hold%0d", i), 3, 8, 0, 1);
    end
    hold = 1'b0;
    step();
    chk4("posthold", 3, 8, 0, 0);
    step();
    chk4("holdwrap", 0, 1, 1, 2);

    // 3: forced advance, then adv_req masked by hold
    adv_req = 1'b1;
    step();
    adv_req = 1'b0;
    chk4("adv", 1, 2, 1, 0);
    hold = 1'b1; adv_req = 1'b1;
    step();
    chk4("advhold", 1, 2, 0, 0);
    hold = 1'b0; adv_req = 1'b0;
    step();
    chk4("toph2", 2, 4, 1, 1);

    // 4: lower the wrap point while in phase 2
    last_phase = 2'd1;
    step();
    chk4("wrapfin", 2, 4, 0, 0);
    step();
    chk4("wrap0", 0, 1, 1, 2);
    for (int i = 0; i < 8; i++) begin
      step();
      chk4($sformatf("wrap%0d", i + 1), (t4_oh[i] == 2) ? 1 : 0, t4_oh[i], t4_st[i], t4_cn[i]);
    end

    // 5: disable mid-phase, re-enable, mid-phase dwell change, async reset
    last_phase = 2'd3;
    for (int i = 0; i < 4; i++) step();
    chk4("inph2", 2, 4, 1, 1);
    en = 1'b0;
    step();
    chk4("dis", 0, 0, 0, 0);
    step();
    chk4("idle", 0, 0, 0, 0);
    en = 1'b1;
    step();
    chk4("reen", 0, 1, 1, 2);
    dwell_bus = 16'h3105;
    step();
    chk4("dwchg", 0, 1, 0, 1);
    dwell_bus = 16'h3102;
    #2;
    rst_n = 1'b0;
    #1;
    chk4("arst", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk4("rstart", 0, 1, 1, 2);

    // 6: 8 phases, all dwell 0
    en8 = 1'b1;
    step();
    chk8("sw0", 0, 1, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk8($sformatf("sw%0d", i), i % 8, 1 << (i % 8), 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
